// File: rtl/aes_sbox_sched.sv
// Issue scheduler for a shared pipelined masked AES S-box: two-port arbitration with
// anti-starvation, randomness streaming, and a tag pipeline that routes results home.
module aes_sbox_sched #(
  parameter int SHARES     = 2,
  parameter int LATENCY    = 5,
  parameter int RNDZ_W     = 18,
  parameter int RNDB_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic                ClkxCI,
  input  logic                RstxBI,
  input  logic                Req0ValidxSI,
  output logic                Req0ReadyxSO,
  input  logic [8*SHARES-1:0] Req0DataxDI,
  input  logic [3:0]          Req0IdxDI,
  input  logic                Req1ValidxSI,
  output logic                Req1ReadyxSO,
  input  logic [8*SHARES-1:0] Req1DataxDI,
  input  logic [3:0]          Req1IdxDI,
  output logic                Rsp0ValidxSO,
  output logic                Rsp1ValidxSO,
  output logic [8*SHARES-1:0] RspDataxDO,
  output logic [3:0]          RspIdxDO,
  input  logic                RndValidxSI,
  output logic                RndReadyxSO,
  input  logic [RNDZ_W-1:0]   RndZxDI,
  input  logic [RNDB_W-1:0]   RndBxDI,
  output logic [8*SHARES-1:0] SboxXxDO,
  output logic [RNDZ_W-1:0]   SboxZxDO,
  output logic [RNDB_W-1:0]   SboxBxDO,
  input  logic [8*SHARES-1:0] SboxQxDI,
  input  logic                FlushxSI,
  output logic                BusyxSO,
  output logic                RndErrxSO
);

  localparam int DW = 8 * SHARES;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  logic               issue_s;
  logic               grant1_s;
  logic               any_tag_s;
  logic               rnd_ready_s;
  logic               rsp_ok_s;
  logic               starve_full_s;
  logic [LATENCY-1:0] tag_valid_r;
  logic [LATENCY-1:0] tag_src_r;
  logic [3:0]         tag_idx_r [LATENCY];
  logic [CW-1:0]      starve_r;
  logic               rnd_err_r;

  // Arbitration, issue qualification and response qualification
  always_comb begin
    any_tag_s     = |tag_valid_r;
    starve_full_s = (starve_r == STARVE_TOP);
    grant1_s      = Req1ValidxSI & (~Req0ValidxSI | starve_full_s);
    issue_s       = RstxBI & RndValidxSI & ~FlushxSI & (Req0ValidxSI | Req1ValidxSI);
    rnd_ready_s   = RstxBI & RndValidxSI & (issue_s | any_tag_s);
    rsp_ok_s      = RstxBI & ~FlushxSI & tag_valid_r[LATENCY-1];
  end

  // Handshake, S-box drive and response outputs; idle buses are forced to zero
  always_comb begin
    Req0ReadyxSO = issue_s & ~grant1_s;
    Req1ReadyxSO = issue_s & grant1_s;
    RndReadyxSO  = rnd_ready_s;
    BusyxSO      = RstxBI & (issue_s | any_tag_s);
    Rsp0ValidxSO = rsp_ok_s & ~tag_src_r[LATENCY-1];
    Rsp1ValidxSO = rsp_ok_s & tag_src_r[LATENCY-1];
    RspIdxDO     = tag_idx_r[LATENCY-1];
    SboxXxDO     = {DW{1'b0}};
    SboxZxDO     = {RNDZ_W{1'b0}};
    SboxBxDO     = {RNDB_W{1'b0}};
    RspDataxDO   = {DW{1'b0}};
    if (issue_s) begin
      if (grant1_s) begin
        SboxXxDO = Req1DataxDI;
      end else begin
        SboxXxDO = Req0DataxDI;
      end
    end else begin
      SboxXxDO = {DW{1'b0}};
    end
    if (rnd_ready_s) begin
      SboxZxDO = RndZxDI;
      SboxBxDO = RndBxDI;
    end else begin
      SboxZxDO = {RNDZ_W{1'b0}};
      SboxBxDO = {RNDB_W{1'b0}};
    end
    if (rsp_ok_s) begin
      RspDataxDO = SboxQxDI;
    end else begin
      RspDataxDO = {DW{1'b0}};
    end
  end

  assign RndErrxSO = rnd_err_r;

  // Tag pipeline, starvation counter and sticky randomness error
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      tag_valid_r <= {LATENCY{1'b0}};
      tag_src_r   <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        tag_idx_r[i] <= 4'h0;
      end
      starve_r  <= {CW{1'b0}};
      rnd_err_r <= 1'b0;
    end else begin
      // The S-box never stalls, so tags advance every cycle whether valid or not
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_src_r[i] <= tag_src_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
      tag_src_r[0] <= grant1_s;
      tag_idx_r[0] <= grant1_s ? Req1IdxDI : Req0IdxDI;
      if (FlushxSI) begin
        tag_valid_r <= {LATENCY{1'b0}};
      end else begin
        for (int i = LATENCY - 1; i > 0; i--) begin
          tag_valid_r[i] <= tag_valid_r[i-1];
        end
        tag_valid_r[0] <= issue_s;
      end
      if (FlushxSI || !Req1ValidxSI || (issue_s && grant1_s)) begin
        starve_r <= {CW{1'b0}};
      end else if (!starve_full_s) begin
        starve_r <= starve_r + CW'(1);
      end else begin
        starve_r <= starve_r;
      end
      if (any_tag_s && !RndValidxSI) begin
        rnd_err_r <= 1'b1;
      end else begin
        rnd_err_r <= rnd_err_r;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for aes_sbox_sched: a behavioural AES S-box stub feeds SboxQ, and a
// cycle-level reference model with a response scoreboard checks every output each cycle.
module tb_aes_sbox_sched;

  localparam int SHARES = 2;
  localparam int LAT    = 5;
  localparam int ZW     = 18;
  localparam int BW     = 16;
  localparam int SMAX   = 3;

  logic        clk;
  logic        rst_n;
  logic        v0, v1, rdy0, rdy1;
  logic [15:0] d0, d1;
  logic [3:0]  i0, i1;
  logic        rsp0, rsp1;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_idx;
  logic        rv, rnd_ready;
  logic [17:0] rz, sbox_z;
  logic [15:0] rb, sbox_b;
  logic [15:0] sbox_x, sbox_q;
  logic        fl, busy, rnd_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit hs0, hs1;

  aes_sbox_sched #(.SHARES(SHARES), .LATENCY(LAT), .RNDZ_W(ZW), .RNDB_W(BW), .STARVE_MAX(SMAX)) dut (
    .ClkxCI(clk), .RstxBI(rst_n),
    .Req0ValidxSI(v0), .Req0ReadyxSO(rdy0), .Req0DataxDI(d0), .Req0IdxDI(i0),
    .Req1ValidxSI(v1), .Req1ReadyxSO(rdy1), .Req1DataxDI(d1), .Req1IdxDI(i1),
    .Rsp0ValidxSO(rsp0), .Rsp1ValidxSO(rsp1), .RspDataxDO(rsp_data), .RspIdxDO(rsp_idx),
    .RndValidxSI(rv), .RndReadyxSO(rnd_ready), .RndZxDI(rz), .RndBxDI(rb),
    .SboxXxDO(sbox_x), .SboxZxDO(sbox_z), .SboxBxDO(sbox_b), .SboxQxDI(sbox_q),
    .FlushxSI(fl), .BusyxSO(busy), .RndErrxSO(rnd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    logic       hi;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // AES S-box from first principles: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Masked S-box stub: remasks with the input's upper share, LAT-cycle delay
  logic [15:0] stub_pipe [LAT];
  initial for (int k = 0; k < LAT; k++) stub_pipe[k] = 16'h0000;
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) stub_pipe[k] <= stub_pipe[k-1];
    stub_pipe[0] <= {sbox_x[15:8], sbox_f(sbox_x[7:0] ^ sbox_x[15:8]) ^ sbox_x[15:8]};
  end
  assign sbox_q = stub_pipe[LAT-1];

  typedef struct {
    int         due;
    bit         src;
    logic [3:0] idx;
    logic [7:0] val;
  } exp_t;
  exp_t q[$];
  int   m_starve = 0;
  bit   m_err    = 1'b0;

  // Reference model and per-cycle comparison, mid-cycle when all inputs are stable
  always @(negedge clk) begin : compare
    bit          iss, g1, anyt, rr, due_now;
    logic [15:0] ex_x, dsel;
    cyc++;
    if (!rst_n) begin
      chk("rst_rdy0", 32'(rdy0), 32'd0);
      chk("rst_rdy1", 32'(rdy1), 32'd0);
      chk("rst_rsp0", 32'(rsp0), 32'd0);
      chk("rst_rsp1", 32'(rsp1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_x", 32'(sbox_x), 32'd0);
      chk("rst_z", 32'(sbox_z), 32'd0);
      chk("rst_b", 32'(sbox_b), 32'd0);
      chk("rst_rndrdy", 32'(rnd_ready), 32'd0);
      chk("rst_err", 32'(rnd_err), 32'(m_err));
      q.delete();
      m_starve = 0;
      m_err    = 1'b0;
    end else begin
      anyt = (q.size() > 0);
      iss  = rv && !fl && (v0 || v1);
      g1   = v1 && (!v0 || m_starve == SMAX);
      dsel = g1 ? d1 : d0;
      ex_x = iss ? dsel : 16'h0000;
      rr   = rv && (iss || anyt);
      chk("rdy0", 32'(rdy0), 32'(iss && !g1));
      chk("rdy1", 32'(rdy1), 32'(iss && g1));
      chk("sbox_x", 32'(sbox_x), 32'(ex_x));
      chk("rnd_ready", 32'(rnd_ready), 32'(rr));
      chk("sbox_z", 32'(sbox_z), rr ? 32'(rz) : 32'd0);
      chk("sbox_b", 32'(sbox_b), rr ? 32'(rb) : 32'd0);
      chk("busy", 32'(busy), 32'(iss || anyt));
      chk("rnd_err", 32'(rnd_err), 32'(m_err));
      due_now = anyt && (q[0].due == cyc);
      if (due_now && !fl) begin
        chk("rsp0_v", 32'(rsp0), 32'(!q[0].src));
        chk("rsp1_v", 32'(rsp1), 32'(q[0].src));
        chk("rsp_idx", 32'(rsp_idx), 32'(q[0].idx));
        chk("rsp_val", 32'(rsp_data[7:0] ^ rsp_data[15:8]), 32'(q[0].val));
      end else begin
        chk("rsp0_idle", 32'(rsp0), 32'd0);
        chk("rsp1_idle", 32'(rsp1), 32'd0);
        chk("rsp_data_idle", 32'(rsp_data), 32'd0);
      end
      if (anyt && !rv) m_err = 1'b1;
      if (fl) begin
        q.delete();
        m_starve = 0;
      end else begin
        if (due_now) void'(q.pop_front());
        if (iss) q.push_back('{cyc + LAT, g1, g1 ? i1 : i0, sbox_f(dsel[7:0] ^ dsel[15:8])});
        if (v1 && !(iss && g1)) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else m_starve = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    hs0 = v0 && rdy0;
    hs1 = v1 && rdy1;
    @(posedge clk);
    #1;
    rz = 18'($urandom);
    rb = 16'($urandom);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         sent, n0, n1;
    logic [7:0] mask;
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 16'h0; d1 = 16'h0; i0 = 4'h0; i1 = 4'h0;
    rv = 1'b1; fl = 1'b0; rz = 18'h0; rb = 16'h0;

    chk("sbox_00", 32'(sbox_f(8'h00)), 32'h63);
    chk("sbox_01", 32'(sbox_f(8'h01)), 32'h7c);
    chk("sbox_53", 32'(sbox_f(8'h53)), 32'hed);
    chk("sbox_ff", 32'(sbox_f(8'hff)), 32'h16);

    drain(2);
    rst_n = 1'b1;
    drain(1);

    // Single port-0 byte 0x00 as shares (5A,5A), index 3
    v0 = 1'b1; d0 = 16'h5A5A; i0 = 4'd3;
    tick();
    v0 = 1'b0;
    drain(4);
    @(negedge clk);
    chk("t1_rsp0", 32'(rsp0), 32'd1);
    chk("t1_idx", 32'(rsp_idx), 32'd3);
    chk("t1_val", 32'(rsp_data[7:0] ^ rsp_data[15:8]), 32'h63);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_pulse", 32'(rsp0), 32'd0);
    @(posedge clk); #1;
    drain(3);

    // Port 1 streams 16 masked bytes back to back
    sent = 0;
    mask = 8'($urandom);
    v1 = 1'b1; d1 = {mask, 8'h03 ^ mask}; i1 = 4'd0;
    for (int n = 0; n < 40 && sent < 16; n++) begin
      tick();
      if (hs1) begin
        sent++;
        mask = 8'($urandom);
        d1 = {mask, 8'(sent * 17 + 3) ^ mask};
        i1 = 4'(sent);
        if (sent == 16) v1 = 1'b0;
      end
    end
    v1 = 1'b0;
    chk("t2_sent", 32'(sent), 32'd16);
    drain(8);

    // Both ports request continuously: expect grants 0,0,0,1 repeating
    n0 = 0; n1 = 0;
    v0 = 1'b1; v1 = 1'b1; d0 = 16'h1100; d1 = 16'h22C0; i0 = 4'd0; i1 = 4'd0;
    for (int n = 0; n < 24; n++) begin
      tick();
      if (hs0) begin n0++; d0 = {8'(n0 * 5), 8'(n0 * 29)}; i0 = 4'(n0); end
      if (hs1) begin n1++; d1 = {8'(n1 * 7), 8'(n1 * 41 + 1)}; i1 = 4'(n1); end
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("t3_grants0", 32'(n0), 32'd18);
    chk("t3_grants1", 32'(n1), 32'd6);
    drain(8);

    // Randomness drops for 2 cycles with 3 bytes in flight and a 4th pending
    v0 = 1'b1; d0 = 16'h0A10; i0 = 4'd1;
    tick(); d0 = 16'h0B20; i0 = 4'd2;
    tick(); d0 = 16'h0C30; i0 = 4'd3;
    tick(); d0 = 16'h0D40; i0 = 4'd4;
    rv = 1'b0;
    drain(2);
    rv = 1'b1;
    tick();
    v0 = 1'b0;
    drain(8);
    @(negedge clk);
    chk("t4_err", 32'(rnd_err), 32'd1);
    @(posedge clk); #1;

    // Flush two in-flight bytes; nothing must come back
    v1 = 1'b1; d1 = 16'h3344; i1 = 4'd7;
    tick(); d1 = 16'h5566; i1 = 4'd8;
    tick();
    v1 = 1'b0;
    tick();
    fl = 1'b1;
    tick();
    fl = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    v0 = 1'b1; d0 = 16'h7788; i0 = 4'd9;
    tick();
    v0 = 1'b0;
    drain(8);

    // Reset for one edge mid-stream
    v0 = 1'b1; d0 = 16'h99AA; i0 = 4'd10;
    tick(); d0 = 16'hBBCC; i0 = 4'd11;
    tick(); d0 = 16'hDDEE; i0 = 4'd12;
    tick();
    v0 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_err", 32'(rnd_err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    drain(7);
    v1 = 1'b1; d1 = 16'h0F0F; i1 = 4'd13;
    tick();
    v1 = 1'b0;
    drain(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
